seg7_pattern_decoder: RTL and testbench

//  Inverse of the hex-to-7-segment path: samples an active-low 7-seg bus (HEX[6:0] = g..a).

---
 rtl/seg7_pattern_decoder.sv | 155 +++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// Decodes a debounced active-low 7-segment pattern to a hex digit, delivers it on a
// valid/ready handshake and keeps a nibble history. Optional blank handling: SEG7_BLANK_DETECT_EN.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int HIST_DIGITS   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               seg_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [3:0]               out_data,
  output logic                     out_err,
  output logic                     overflow,
  output logic [4*HIST_DIGITS-1:0] history
);

  localparam int                HW        = 4 * HIST_DIGITS;
  localparam int                CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]     C_MAX     = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]     C_HIT     = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]        SEG_BLANK = 7'h7F;
`ifdef SEG7_BLANK_DETECT_EN
  localparam logic              BLANK_EN  = 1'b1;
`else
  localparam logic              BLANK_EN  = 1'b0;
`endif

  typedef enum logic [1:0] {ST_WAIT, ST_EMIT, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [6:0]      seg_q, seg_d;
  logic [6:0]      seg_prev_q, seg_prev_d;
  logic [6:0]      last_q, last_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic            overflow_q, overflow_d;
  logic [HW-1:0]   history_q, history_d;
  logic [HW-1:0]   hist_shift;
  logic [4:0]      dec;
  logic            same, hit, blank;

  // Returns {err, data}; unknown codes give err=1, data=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:        r = 5'h00;
      7'h79:        r = 5'h01;
      7'h24:        r = 5'h02;
      7'h30:        r = 5'h03;
      7'h19:        r = 5'h04;
      7'h12:        r = 5'h05;
      7'h02:        r = 5'h06;
      7'h78, 7'h58: r = 5'h07;
      7'h00:        r = 5'h08;
      7'h10:        r = 5'h09;
      7'h08:        r = 5'h0A;
      7'h03:        r = 5'h0B;
      7'h46:        r = 5'h0C;
      7'h21:        r = 5'h0D;
      7'h06:        r = 5'h0E;
      7'h0E:        r = 5'h0F;
      default:      r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_d       = seg_in;
    seg_prev_d  = seg_q;
    state_d     = state_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    overflow_d  = overflow_q;
    history_d   = history_q;
    dec         = seg_decode(seg_q);
    same        = (seg_q == seg_prev_q);
    count_d     = '0;
    if (same) count_d = (count_q == C_MAX) ? count_q : count_q + CW'(1);
    // The counter passes through C_HIT only once per run, so a held pattern triggers once.
    hit         = (count_d == C_HIT);
    blank       = BLANK_EN && (seg_q == SEG_BLANK);
    hist_shift       = history_q << 4;
    hist_shift[3:0]  = out_data_q;

    case (state_q)
      ST_WAIT, ST_HOLD: begin
        if (hit) begin
          if (blank) begin
            state_d = ST_HOLD;
            last_d  = SEG_BLANK;
          end else if (seg_q == last_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d                 = ST_EMIT;
            out_valid_d             = 1'b1;
            {out_err_d, out_data_d} = dec;
            last_d                  = seg_q;
          end
        end else if (state_q == ST_HOLD && !same) begin
          state_d = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (hit) begin
          if (blank) last_d = SEG_BLANK;
          else if (seg_q != last_q) overflow_d = 1'b1;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!out_err_q) history_d = hist_shift;
          state_d = (seg_q != last_q) ? ST_WAIT : ST_HOLD;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      seg_q       <= SEG_BLANK;
      seg_prev_q  <= SEG_BLANK;
      last_q      <= SEG_BLANK;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'h0;
      out_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      history_q   <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      seg_prev_q  <= seg_prev_d;
      last_q      <= last_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      overflow_q  <= overflow_d;
      history_q   <= history_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign overflow  = overflow_q;
  assign history   = history_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Self-checking bench for seg7_pattern_decoder: directed scenarios plus random patterns
// compared against a run-length reference model.
module tb_seg7_pattern_decoder;

  localparam int S = 4;
  localparam int H = 4;

`ifdef SEG7_BLANK_DETECT_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   seg_in = 7'h7F;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [3:0]   out_data;
  logic         out_err;
  logic         overflow;
  logic [4*H-1:0] history;

  int total = 0;
  int bad   = 0;

  seg7_pattern_decoder #(.STABLE_CYCLES(S), .HIST_DIGITS(H)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .overflow(overflow), .history(history)
  );

  always #5 clk = ~clk;

  // Reference model: run length of the sampled pattern plus handshake bookkeeping.
  logic [6:0]     m_seg, m_last;
  int             m_run;
  bit             m_valid, m_err, m_ovf;
  logic [3:0]     m_data;
  logic [4*H-1:0] m_hist;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    logic [6:0] codes [17];
    logic [3:0] vals  [17];
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h58,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vals  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7,
              4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 17; i++)
      if (codes[i] == s) return {1'b0, vals[i]};
    return 5'h10;
  endfunction

  task automatic mdl_reset();
    m_seg = 7'h7F; m_last = 7'h7F;
    m_run = 2;  // seg register and its previous copy both reset to the blank code
    m_valid = 0; m_err = 0; m_ovf = 0; m_data = 4'h0; m_hist = '0;
  endtask

  task automatic mdl_edge(input logic [6:0] v, input logic rdy);
    bit was_valid;
    was_valid = m_valid;
    if (m_run == S) begin
      if (BLANK_EN && m_seg == 7'h7F) m_last = 7'h7F;
      else if (was_valid) begin
        if (m_seg != m_last) m_ovf = 1;
      end else if (m_seg != m_last) begin
        m_valid = 1;
        {m_err, m_data} = ref_decode(m_seg);
        m_last = m_seg;
      end
    end
    if (was_valid && rdy) begin
      m_valid = 0;
      if (!m_err) m_hist = (m_hist << 4) | (4*H)'(m_data);
    end
    if (v == m_seg) m_run = (m_run > S) ? S + 1 : m_run + 1;
    else m_run = 1;
    m_seg = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("valid",    32'(out_valid), 32'(m_valid));
    chk("data",     32'(out_data),  32'(m_data));
    chk("err",      32'(out_err),   32'(m_err));
    chk("overflow", 32'(overflow),  32'(m_ovf));
    chk("history",  32'(history),   32'(m_hist));
  endtask

  task automatic step(input logic [6:0] v, input logic rdy);
    seg_in = v; out_ready = rdy;
    @(posedge clk);
    mdl_edge(v, rdy);
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; seg_in = 7'h7F; out_ready = 1'b0;
    mdl_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_all();
  endtask

  initial begin : main
    int first_v, vcnt, errcnt;
    logic [6:0] pool [20];
    pool = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h58, 7'h00,
             7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h55, 7'h7F, 7'h7F};

    // 1: single digit, consumer always ready
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_hist", 32'(history), 0);
    first_v = 0; vcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step(7'h24, 1'b1);
      if (out_valid) begin
        vcnt++;
        if (first_v == 0) first_v = i;
      end
    end
    chk("t1_first_edge", 32'(first_v), 5);
    chk("t1_pulse_len", 32'(vcnt), 1);
    chk("t1_history", 32'(history), 32'h0002);

    // 2: second stable pattern dropped while first waits for ready
    for (int i = 0; i < 8; i++)  step(7'h30, 1'b0);
    for (int i = 0; i < 12; i++) step(7'h12, 1'b0);
    chk("t2_valid_held", 32'(out_valid), 1);
    chk("t2_data_held", 32'(out_data), 3);
    chk("t2_overflow", 32'(overflow), 1);
    step(7'h12, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(7'h12, 1'b1);
      if (out_valid) vcnt++;
    end
    chk("t2_no_reemit", 32'(vcnt), 0);
    chk("t2_history", 32'(history), 32'h0023);

    // 3: fast toggling never settles
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step((i % 4 < 2) ? 7'h00 : 7'h10, 1'b1);
      if (out_valid) vcnt++;
    end
    chk("t3_no_valid", 32'(vcnt), 0);

    // 4: invalid code
    vcnt = 0; errcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(7'h55, 1'b1);
      if (out_valid) begin
        vcnt++;
        if (out_err && out_data == 4'h0) errcnt++;
      end
    end
    chk("t4_valid_cnt", 32'(vcnt), 1);
    chk("t4_err_emit", 32'(errcnt), 1);
    chk("t4_history", 32'(history), 32'h0023);

    // 5: digits separated by blanks
    do_reset();
    errcnt = 0;
    for (int d = 0; d < 5; d++) begin
      for (int i = 0; i < 6; i++) begin
        step(pool[d + 1], 1'b1);
        if (out_valid && out_err) errcnt++;
      end
      for (int i = 0; i < 6; i++) begin
        step(7'h7F, 1'b1);
        if (out_valid && out_err) errcnt++;
      end
    end
    chk("t5_history", 32'(history), 32'h2345);
    chk("t5_err_emits", 32'(errcnt), BLANK_EN ? 0 : 5);

    // 6: same digit after blank re-emits, then async reset mid-handshake
    for (int i = 0; i < 6; i++) step(7'h12, 1'b0);
    chk("t6_reemit", 32'(out_valid), 1);
    chk("t6_data", 32'(out_data), 5);
    for (int i = 0; i < 6; i++) step(7'h79, 1'b0);
    chk("t6_ovf_set", 32'(overflow), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_hist", 32'(history), 0);
    chk("t6_async_ovf", 32'(overflow), 0);
    mdl_reset();
    seg_in = 7'h7F; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random patterns, hold lengths and ready behaviour
    for (int b = 0; b < 300; b++) begin
      logic [6:0] v;
      int hold;
      v = pool[$urandom_range(0, 19)];
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) step(v, ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
